// File: rtl/skew_pkg.sv
// Shared types and sizing helpers for the skewed tile feeder.
// The state encoding and counter sizing live here so every file agrees on them.
package skew_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DEF_DIM  = 8;
    localparam int DEF_BITS = 8;

    // A full wavefront is 2*DIM-1 steps; the counter holds 0..2*DIM-2.
    function automatic int steps(input int dim);
        return 2 * dim - 1;
    endfunction

    function automatic int cnt_w(input int dim);
        return $clog2(2 * dim);
    endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// Per-lane element select: picks vec element (t - LANE) or zero outside the window.
// Purely combinational, no latency, no backpressure.
// Only compile-time offsets are compared, so no out-of-range index is ever formed.
module skew_lane_mux
    import skew_pkg::*;
#(
    parameter int DIM  = DEF_DIM,
    parameter int BITS = DEF_BITS,
    parameter int LANE = 0
) (
    input  logic [cnt_w(DIM)-1:0] t,
    input  logic [DIM*BITS-1:0]   vec,
    output logic [BITS-1:0]       elem
);

    always_comb begin
        elem = '0;
        for (int k = 0; k < DIM; k++) begin
            if (int'(t) == LANE + k) begin
                elem = vec[k*BITS +: BITS];
            end
        end
    end

endmodule

// File: rtl/skew_feeder.sv
// Holds a DIM x DIM tile and streams it as a diagonally skewed, zero-padded wavefront.
// Latency: step 0 registered one cycle after start is sampled; 2*DIM-1 steps, then a done pulse.
// Backpressure: stall freezes the step counter and holds out_data with out_en low.
// Build option SKEW_FEEDER_TRANSPOSE_EN: lane i streams column i instead of row i.
module skew_feeder
    import skew_pkg::*;
#(
    parameter int DIM  = DEF_DIM,
    parameter int BITS = DEF_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(DIM)-1:0]  wr_row,
    input  logic [DIM*BITS-1:0]     wr_data,
    input  logic                    start,
    input  logic                    stall,
    output logic                    busy,
    output logic                    out_en,
    output logic [DIM*BITS-1:0]     out_data,
    output logic                    done
);

    localparam int TW = cnt_w(DIM);
    localparam logic [TW-1:0] T_LAST = TW'(steps(DIM) - 1);

    state_t            state;
    logic [TW-1:0]     t;
    logic [BITS-1:0]   mat [DIM][DIM];
    logic [DIM*BITS-1:0] lane_vec [DIM];
    logic [DIM*BITS-1:0] lane_out;

    // Tile storage: writable only while idle, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    mat[r][c] <= '0;
                end
            end
        end else if (state == IDLE && wr_en && int'(wr_row) < DIM) begin
            for (int c = 0; c < DIM; c++) begin
                mat[wr_row][c] <= wr_data[c*BITS +: BITS];
            end
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        for (genvar k = 0; k < DIM; k++) begin : g_elem
`ifdef SKEW_FEEDER_TRANSPOSE_EN
            assign lane_vec[i][k*BITS +: BITS] = mat[k][i];
`else
            assign lane_vec[i][k*BITS +: BITS] = mat[i][k];
`endif
        end

        skew_lane_mux #(
            .DIM  (DIM),
            .BITS (BITS),
            .LANE (i)
        ) u_lane_mux (
            .t    (t),
            .vec  (lane_vec[i]),
            .elem (lane_out[i*BITS +: BITS])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            t        <= '0;
            busy     <= 1'b0;
            out_en   <= 1'b0;
            out_data <= '0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_en   <= 1'b0;
                    out_data <= '0;
                    done     <= 1'b0;
                    if (start) begin
                        state <= STREAM;
                        t     <= '0;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    done <= 1'b0;
                    if (stall) begin
                        out_en <= 1'b0;
                    end else begin
                        out_en   <= 1'b1;
                        out_data <= lane_out;
                        if (t == T_LAST) begin
                            state <= DONE;
                            t     <= '0;
                        end else begin
                            t <= t + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    out_en   <= 1'b0;
                    out_data <= '0;
                    done     <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    t        <= '0;
                    busy     <= 1'b0;
                    out_en   <= 1'b0;
                    out_data <= '0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/skew_feeder.md
Name: skew_feeder

Overview:
- Upstream stage of the fifo delay buffers that feed the systolic MAC array.
- Holds a DIM x DIM operand tile loaded row by row.
- On start, streams the tile out as a diagonally skewed wavefront: lane i lags lane i-1 by one cycle, zero-padded.
- out_en drives the downstream fifo en inputs directly.

Parameters:
- DIM, 8, tile dimension (rows = lanes = columns); must be >= 2
- BITS, 8, element width per lane

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- wr_en  input  1  row write strobe; honoured in IDLE only
- wr_row  input  $clog2(DIM)  row index to write
- wr_data  input  DIM*BITS  row data; element c = wr_data[c*BITS +: BITS]
- start  input  1  begin streaming; honoured in IDLE only
- stall  input  1  downstream hold; freezes the stream
- busy  output  1  high in STREAM and DONE
- out_en  output  1  lane data valid this cycle; wire to fifo en
- out_data  output  DIM*BITS  lane i = out_data[i*BITS +: BITS]
- done  output  1  one-cycle pulse after the last step

Behaviour:
- Reset (synchronous, checked every edge, overrides everything):
  - state=IDLE, step counter t=0.
  - All tile entries mat[r][c]=0.
  - busy=0, out_en=0, out_data=0, done=0.
- Storage: mat[DIM][DIM] of BITS.
  - In IDLE, wr_en writes mat[wr_row][c] <= element c for all c.
  - wr_row >= DIM: write dropped.
  - wr_en outside IDLE: ignored, no write.
- State machine:
  - IDLE: start=1 -> STREAM with t=0.
  - STREAM: t runs from 0 to 2*DIM-2. After step 2*DIM-2 is emitted -> DONE.
  - DONE: lasts exactly one cycle, then IDLE.
- Output rule:
  - All outputs are registered.
  - In STREAM with stall=0, the next edge sets out_en=1 and out_data lane i = mat[i][t-i] when 0 <= t-i <= DIM-1, else 0. t then increments.
  - In STREAM with stall=1: t holds, out_en=0, out_data holds its last value.
- Latency:
  - start sampled at edge k -> step 0 appears after edge k+1.
  - Unstalled stream: 2*DIM-1 consecutive out_en cycles.
  - done=1 in the cycle after the last out_en.
  - DONE and IDLE: out_en=0, out_data=0.
- Simultaneous events:
  - wr_en and start together in IDLE: the write commits and the stream uses the new row.
  - start while busy: ignored.
  - stall in IDLE or DONE: no effect.
  - stall on the final step: the step is delayed until stall drops.
- Reset mid-stream: immediate abort, all state as after reset, no done pulse.
- Tile contents persist across streams; they are cleared only by reset.

Optional Feature:
- Macro: SKEW_FEEDER_TRANSPOSE_EN.
- Defined: lane i streams column i, i.e. out lane i = mat[t-i][i]. Skew, zero padding and timing are unchanged. Used for the B-operand side.
- Undefined: lane i streams row i, as specified above.
- The port list is identical in both builds.

Decomposition:
- Shared package skew_pkg holds:
  - state enum typedef {IDLE, STREAM, DONE}
  - default DIM/BITS constants
  - STEPS = 2*DIM-1 and step-counter width $clog2(2*DIM) as localparams/functions
- One sub-module, skew_lane_mux: per-lane combinational select of mat element or zero given t and lane index. Generated DIM times. Keeps the top to control plus storage.

Test Plan (DIM=4, BITS=8):
1. Load rows 0..3 with element values 8'h00..8'h0F (value = r*4+c), start, no stall -> 7 out_en cycles:
   - lane0 = 00,01,02,03,0,0,0
   - lane3 = 0,0,0,0C,0D,0E,0F
   - done pulses on cycle 8 after start.
2. Same tile, stall held 2 cycles at t=3 -> out_en drops for 2 cycles with out_data held at step 2 values; the sequence resumes; done is delayed by 2 cycles.
3. wr_en row 1 = 8'hAA in all elements, in the same cycle as start -> lane1 emits AA,AA,AA,AA during t=1..4.
4. start, wr_en and a second start during STREAM -> no tile change and no restart; exactly one done.
5. rst_n=0 at t=2 -> next cycle busy=0, out_en=0, out_data=0, no done. A subsequent stream of the untouched tile emits all zeros.
6. SKEW_FEEDER_TRANSPOSE_EN build with the tile from scenario 1 -> lane1 = 0,01,05,09,0D,0,0.
